nor_gate_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises a NOR-gate datapath with dual outputs (d, e).
- The datapath is a NUM_IN-input NOR with two implementations.
- Steps through all 2^NUM_IN input patterns, waits a settle interval per pattern, then samples both outputs against a golden NOR.
- Records per-pattern failures and a pass/fail verdict.
- Sits beside the gate block in the week-4 gate set and replaces free-running toggle stimulus with a clocked, self-checking sweep.

---
 rtl/nor_sweep_pkg.sv | 22 ++
 rtl/nor_gate_sweep_ctrl_settle_timer.sv | 42 ++++
 rtl/nor_gate_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_nor_gate_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nor_sweep_pkg.sv
// Shared types and sizing helpers for the NOR-gate exhaustive sweep sequencer.
package nor_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 6;

  function automatic int pat_count(input int num_in);
    return 1 << num_in;
  endfunction

  function automatic int err_width(input int num_in);
    return num_in + 1;
  endfunction

endpackage

// File: rtl/nor_gate_sweep_ctrl_settle_timer.sv
// Load/decrement settle counter; zero flags the end of a pattern's settle window.
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYC - 1);

  generate
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("settle_timer: SETTLE_CYC must be at least 1");
    end
  endgenerate

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nor_gate_sweep_ctrl.sv
// Clocked exhaustive sweep of a NUM_IN-input NOR with two implementations (d, e),
// recording per-pattern mismatches against a golden NOR and a final verdict.
module nor_gate_sweep_ctrl
  import nor_sweep_pkg::*;
#(
  parameter int NUM_IN     = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  output logic [NUM_IN-1:0]              pat_out,
  input  logic                           d_in,
  input  logic                           e_in,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [err_width(NUM_IN)-1:0]   err_count,
  output logic [pat_count(NUM_IN)-1:0]   fail_vec
);

  localparam int P    = pat_count(NUM_IN);
  localparam int EW   = err_width(NUM_IN);
  localparam logic [NUM_IN-1:0] IDX_LAST = '1;

  generate
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
      $error("nor_gate_sweep_ctrl: NUM_IN out of legal range");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] idx_q, idx_d;
  logic [EW-1:0]     err_q, err_d;
  logic [P-1:0]      fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              exp_bit, mismatch;

  settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  // A pattern counts once even when both implementations disagree with the golden value.
  assign exp_bit  = ~|idx_q;
  assign mismatch = (d_in != exp_bit) | (e_in != exp_bit);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = SETTLE;
            idx_d    = '0;
            err_d    = '0;
            fail_d   = '0;
            pass_d   = 1'b0;
            tmr_load = 1'b1;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            state_d = SAMPLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_d         = err_q + EW'(1);
            fail_d[idx_q] = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            state_d  = SETTLE;
            idx_d    = idx_q + NUM_IN'(1);
            tmr_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign pat_out   = idx_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nor_gate_sweep_ctrl.sv
// Directed bench for nor_gate_sweep_ctrl: defaults instance plus a NUM_IN=2, SETTLE_CYC=1 instance.
module tb_nor_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, start2;
  logic [2:0] pat_out;
  logic       d_in, e_in, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;
  int         mode;

  logic [1:0] pat2;
  logic       d2, e2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] fail2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nor_gate_sweep_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pat_out(pat_out),
    .d_in(d_in), .e_in(e_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  nor_gate_sweep_ctrl #(.NUM_IN(2), .SETTLE_CYC(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .pat_out(pat2),
    .d_in(d2), .e_in(e2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  // Gate models: 0 correct, 1 d stuck-at-0, 2 e inverted, 3 d and e stuck-at-1
  always_comb begin
    d_in = ~|pat_out;
    e_in = ~|pat_out;
    case (mode)
      1: d_in = 1'b0;
      2: e_in = |pat_out;
      3: begin d_in = 1'b1; e_in = 1'b1; end
      default: ;
    endcase
  end

  assign d2 = ~|pat2;
  assign e2 = ~|pat2;

  // Runs one full default sweep from IDLE/DONE; poke>=0 pulses start during that cycle.
  task automatic sweep_check(input string name, input logic [3:0] exp_err,
                             input logic [7:0] exp_fail, input logic exp_pass, input int poke);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (err_count !== 4'd0 || fail_vec !== 8'h00 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_clear: err=%0d fail=%h pass=%b want 0 00 0", name, err_count, fail_vec, pass);
    end
    for (int e = 0; e < 24; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (e + 1 == poke) start = 1'b1;
      vectors++;
      if (pat_out !== 3'(e / 3) || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: pat=%0d busy=%b done=%b want pat=%0d busy=1 done=0",
                 name, e + 1, pat_out, busy, done, e / 3);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || err_count !== exp_err ||
        fail_vec !== exp_fail || pat_out !== 3'd7) begin
      miscompares++;
      $display("FAIL %s_result: done=%b busy=%b pass=%b err=%0d fail=%h pat=%0d want 1 0 %b %0d %h 7",
               name, done, busy, pass, err_count, fail_vec, pat_out, exp_pass, exp_err, exp_fail);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (pat_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        err_count !== 4'd0 || fail_vec !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: pat=%0d busy=%b done=%b pass=%b err=%0d fail=%h want all 0",
               pat_out, busy, done, pass, err_count, fail_vec);
    end
    vectors++;
    if (pat2 !== 2'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || err2 !== 3'd0 || fail2 !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_small: pat=%0d busy=%b done=%b err=%0d fail=%h want all 0",
               pat2, busy2, done2, err2, fail2);
    end
  endtask

  task automatic test_clean();
    mode = 0;
    sweep_check("clean", 4'd0, 8'h00, 1'b1, -1);
  endtask

  task automatic test_d_stuck0();
    mode = 1;
    sweep_check("d_stuck0", 4'd1, 8'h01, 1'b0, -1);
  endtask

  task automatic test_e_inverted();
    mode = 2;
    sweep_check("e_inv", 4'd8, 8'hFF, 1'b0, -1);
  endtask

  task automatic test_both_wrong();
    // Patterns 1..7 have both outputs wrong; each still counts once.
    mode = 3;
    sweep_check("both_wrong", 4'd7, 8'hFE, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    mode = 0;
    sweep_check("start_busy", 4'd0, 8'h00, 1'b1, 5);
  endtask

  task automatic test_abort();
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || pat_out !== 3'd0 ||
        err_count !== 4'd1 || fail_vec !== 8'h01) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b pass=%b pat=%0d err=%0d fail=%h want 0 0 0 0 1 01",
               busy, done, pass, pat_out, err_count, fail_vec);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err_count !== 4'd1) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b done=%b err=%0d want 0 0 1", busy, done, err_count);
    end
    mode = 0;
    sweep_check("after_abort", 4'd0, 8'h00, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (pat_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        err_count !== 4'd0 || fail_vec !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: pat=%0d busy=%b done=%b pass=%b err=%0d fail=%h want all 0",
               pat_out, busy, done, pass, err_count, fail_vec);
    end
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_nodone: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_small();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      vectors++;
      if (pat2 !== 2'(e / 2) || done2 !== 1'b0 || busy2 !== 1'b1) begin
        miscompares++;
        $display("FAIL small_cycle%0d: pat=%0d done=%b busy=%b want pat=%0d done=0 busy=1",
                 e + 1, pat2, done2, busy2, e / 2);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 3'd0 || fail2 !== 4'h0 || pat2 !== 2'd3) begin
      miscompares++;
      $display("FAIL small_result: done=%b pass=%b err=%0d fail=%h pat=%0d want 1 1 0 0 3",
               done2, pass2, err2, fail2, pat2);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_d_stuck0();
    test_e_inverted();
    test_both_wrong();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1, "timeout");
  end

endmodule
